// File: rtl/signal_debouncer_if.sv
// -----------------------------------------------------------------------------
// signal_debouncer_if
//
// Purpose: groups the level-in / level-out signals of signal_debouncer.
//
// Signals:
//   input_signal  - raw asynchronous level (may bounce or glitch)
//   output_signal - debounced level in the clk domain
//   stable        - 1 when no level change is being qualified
//   glitch_count  - saturating count of rejected transitions
//                   (only when SIGNAL_DEBOUNCER_GLITCH_COUNT_EN is defined)
//
// Modports:
//   slave  - the debouncer side (consumes input_signal, drives the rest)
//   master - the environment side (drives input_signal, observes the rest)
// -----------------------------------------------------------------------------
interface signal_debouncer_if;
  logic       input_signal;
  logic       output_signal;
  logic       stable;
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
  logic [7:0] glitch_count;

  modport slave (
    input  input_signal,
    output output_signal,
    output stable,
    output glitch_count
  );

  modport master (
    output input_signal,
    input  output_signal,
    input  stable,
    input  glitch_count
  );
`else
  modport slave (
    input  input_signal,
    output output_signal,
    output stable
  );

  modport master (
    output input_signal,
    input  output_signal,
    input  stable
  );
`endif
endinterface

// File: rtl/signal_debouncer.sv
// -----------------------------------------------------------------------------
// signal_debouncer
//
// Purpose: synchronises a raw asynchronous level through a two-flop chain and
// debounces it. A new level is only accepted once the synchronised input has
// held it for the full qualification window; any reversal during qualification
// is rejected and the previous stable level is kept.
//
// Parameters:
//   DEBOUNCE_CYCLES - qualification length in clk cycles (>= 2)
//   COUNTER_WIDTH   - qualification counter width, 2**COUNTER_WIDTH > DEBOUNCE_CYCLES
//
// Ports:
//   clk   - reference clock
//   rst_n - asynchronous active-low reset
//   dbif  - signal_debouncer_if.slave: input_signal in; output_signal,
//           stable (and glitch_count when enabled) out, all registered
//
// Optional feature macro: SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
//   When defined, an 8-bit saturating count of rejected transitions is kept
//   and driven on dbif.glitch_count; it is cleared only by rst_n.
// -----------------------------------------------------------------------------
module signal_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int COUNTER_WIDTH   = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  signal_debouncer_if.slave   dbif
);

  // Elaboration-time sanity checks on the parameters.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("signal_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((64'd1 << COUNTER_WIDTH) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
    $error("signal_debouncer: COUNTER_WIDTH too small for DEBOUNCE_CYCLES");
  end

  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    QUAL_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    QUAL_LOW    = 2'd3
  } state_t;

  logic                     sync0_q, sync0_d;
  logic                     sync1_q, sync1_d;
  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     output_q, output_d;
  logic                     stable_q, stable_d;

  // Synchroniser chain: sync1_q is the only view of the input the FSM uses.
  always_comb begin
    sync0_d = dbif.input_signal;
    sync1_d = sync0_q;
  end

  // Next-state logic. A reversal of sync1 is tested before completion so a
  // glitch on the would-be completion edge is still rejected. The counter is
  // cleared on every state change and never runs past LAST_COUNT.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    output_d = output_q;

    case (state_q)
      STABLE_LOW: begin
        if (sync1_q) begin
          state_d = QUAL_HIGH;
          count_d = '0;
        end
      end

      QUAL_HIGH: begin
        if (!sync1_q) begin
          state_d = STABLE_LOW;
          count_d = '0;
        end else if (count_q == LAST_COUNT) begin
          state_d  = STABLE_HIGH;
          count_d  = '0;
          output_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      STABLE_HIGH: begin
        if (!sync1_q) begin
          state_d = QUAL_LOW;
          count_d = '0;
        end
      end

      QUAL_LOW: begin
        if (sync1_q) begin
          state_d = STABLE_HIGH;
          count_d = '0;
        end else if (count_q == LAST_COUNT) begin
          state_d  = STABLE_LOW;
          count_d  = '0;
          output_d = 1'b0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      default: begin
        state_d  = STABLE_LOW;
        count_d  = '0;
        output_d = 1'b0;
      end
    endcase

    // stable is registered alongside the state so it tracks state_q exactly.
    stable_d = (state_d == STABLE_LOW) || (state_d == STABLE_HIGH);
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      state_q  <= STABLE_LOW;
      count_q  <= '0;
      output_q <= 1'b0;
      stable_q <= 1'b1;
    end else begin
      sync0_q  <= sync0_d;
      sync1_q  <= sync1_d;
      state_q  <= state_d;
      count_q  <= count_d;
      output_q <= output_d;
      stable_q <= stable_d;
    end
  end

  assign dbif.output_signal = output_q;
  assign dbif.stable        = stable_q;

`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
  logic [7:0] glitch_q, glitch_d;
  logic       reject;

  // A reject is a QUAL_* state seeing sync1 return to the old stable level.
  always_comb begin
    reject   = ((state_q == QUAL_HIGH) && !sync1_q) ||
               ((state_q == QUAL_LOW)  &&  sync1_q);
    glitch_d = glitch_q;
    if (reject && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign dbif.glitch_count = glitch_q;
`endif

endmodule
